huff_coder_sequencer: RTL and testbench
=======================================

Name: huff_coder_sequencer

Overview:
- Host-side controller that drives the Huffman coder's toggle-strobe load/readback protocol, so software or a DMA needs only a start pulse.
- Sequence per job: fetch code table and message from two synchronous read ports, strobe them into the coder, wait for encoding, then strobe out the packed 32-bit result words.
- Results leave on a valid/ready stream; the block waits out the coder's buffer-clear phase before reporting done.

Parameters:
- DEPTH, 100, coder buffer depth; max table entries and max message words (length word included)
- STROBE_HI, 4, cycles coder_ce is held high per strobe (min 3)
- STROBE_LO, 4, cycles coder_ce is held low per strobe (min 3)
- CLEAR_CYCLES, 210, wait after final flush strobe for the coder buffer clear (≥2*DEPTH+4)
- TIMEOUT, 4096, max cycles waiting for coder_data_ready

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle job start pulse; ignored unless idle
- tbl_count  in  8  number of table entries (1..DEPTH)
- msg_len  in  8  message characters (0..DEPTH-1)
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  one-cycle pulse on timeout (accompanies done)
- tbl_addr  out  8  table read address; data valid next cycle
- tbl_symbol  in  8  code bits
- tbl_length  in  32  code length
- tbl_char  in  8  character
- msg_addr  out  8  message read address; data valid next cycle
- msg_char  in  8  message character at msg_addr
- coder_ce  out  1  strobe to coder clockEnable
- coder_data_loaded  out  1  to coder dataLoaded
- coder_msg_loaded  out  1  to coder messageLoaded
- coder_manual_reset  out  1  to coder manualReset
- coder_symbol  out  8;  coder_symbol_length  out  32;  coder_character  out  8;  coder_message  out  8
- coder_data_ready  in  16  coder dataReady
- coder_data_out  in  32  coder dataOut
- out_valid  out  1;  out_data  out  32;  out_last  out  1;  out_ready  in  1

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-job aborts immediately with no done pulse, and coder_manual_reset pulses for one cycle on the first cycle after reset deasserts.
- Strobe: coder_ce high for STROBE_HI cycles, then low for STROBE_LO cycles. Coder data/flag outputs are stable from one cycle before the ce rise until the ce fall.
- IDLE: on start, latch tbl_count/msg_len, set idx=0, busy=1, go to FETCH.
- FETCH: drive tbl_addr=idx and msg_addr=idx-1, wait 1 cycle, then register the coder data.
  - Message word 0 is msg_len itself (the coder's length convention); words 1..msg_len are msg_char.
  - coder_data_loaded = (idx ≥ tbl_count); coder_msg_loaded = (idx > msg_len).
  - Go to LOAD_HI.
- LOAD_HI then LOAD_LO: one strobe.
  - If both flags were set during this strobe, go to WAIT_READY.
  - Otherwise idx++ and return to FETCH.
  - Total load strobes = max(tbl_count, msg_len+1)+1.
- WAIT_READY: wait for coder_data_ready ≠ 0.
  - On TIMEOUT expiry, pulse coder_manual_reset, pulse err and done, and return to IDLE.
- READ_HI then READ_LO: one strobe, then capture coder_data_out into out_data, set out_valid=1, and go to EMIT.
  - On word 0, compute nwords = (data[31:16]+16+31)>>5, using 17-bit arithmetic.
- EMIT: hold out_valid/out_data until out_ready is seen.
  - out_last=1 on word nwords-1.
  - On acceptance: word count++. If last, go to FLUSH; else go to READ_HI.
  - No strobe is issued while the output is stalled.
- FLUSH: one extra strobe (moves the coder into its clear phase), then CLEAR_WAIT.
- CLEAR_WAIT: count CLEAR_CYCLES, then pulse done for 1 cycle, busy=0, go to IDLE.
- Boundaries:
  - msg_len=0 produces 1 output word (the header).
  - tbl_count and msg_len+1 are each clamped to DEPTH.
  - start while busy is ignored.
  - out_ready held high gives a throughput of 1 word per STROBE_HI+STROBE_LO+1 cycles.

Test Plan:
- tbl_count=3, msg_len=0 -> 4 load strobes, final with both flags=1. One output word 0x0000_0000 with out_last=1, then done after CLEAR_CYCLES.
- Table {' ',len2,code 0b10}, msg_len=2, "  " -> bits=4. Output 0x0004_A000 (header 4 <<16, codes at bit15..12) with out_last=1.
- Message totalling 40 code bits -> nwords=2, two output beats, out_last only on the 2nd.
- out_ready low for 50 cycles during word 0 -> out_valid/out_data stable, coder_ce not toggled until acceptance.
- coder_data_ready stuck 0 with TIMEOUT=64 -> coder_manual_reset pulse, err and done asserted together at cycle 64, busy falls.
- reset asserted during LOAD -> outputs return to 0, coder_manual_reset pulses once after release, no done; a subsequent start runs normally.

Source files
------------

// File: rtl/huff_coder_sequencer.sv
// Sequences one Huffman coder job: fetch table/message entries, strobe them in,
// wait for the encoding, strobe the packed result words out onto a valid/ready stream.
module huff_coder_sequencer #(
    parameter int DEPTH        = 100,
    parameter int STROBE_HI    = 4,
    parameter int STROBE_LO    = 4,
    parameter int CLEAR_CYCLES = 210,
    parameter int TIMEOUT      = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  tbl_count,
    input  logic [7:0]  msg_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  tbl_addr,
    input  logic [7:0]  tbl_symbol,
    input  logic [31:0] tbl_length,
    input  logic [7:0]  tbl_char,
    output logic [7:0]  msg_addr,
    input  logic [7:0]  msg_char,
    output logic        coder_ce,
    output logic        coder_data_loaded,
    output logic        coder_msg_loaded,
    output logic        coder_manual_reset,
    output logic [7:0]  coder_symbol,
    output logic [31:0] coder_symbol_length,
    output logic [7:0]  coder_character,
    output logic [7:0]  coder_message,
    input  logic [15:0] coder_data_ready,
    input  logic [31:0] coder_data_out,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready
);
    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD_HI, LOAD_LO, WAIT_READY, READ_HI, READ_LO,
        EMIT, FLUSH_HI, FLUSH_LO, CLEAR_WAIT
    } state_t;

    localparam logic [15:0] HI_LAST  = 16'(STROBE_HI - 1);
    localparam logic [15:0] LO_LAST  = 16'(STROBE_LO - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] CLR_LAST = 16'(CLEAR_CYCLES - 1);
    localparam logic [8:0]  DEPTH9   = 9'(DEPTH);

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  idx;
    logic [7:0]  tblLimit;
    logic [7:0]  msgWords;
    logic [7:0]  msgLenReg;
    logic [11:0] wordCnt;
    logic [11:0] nWords;
    logic        postReset;

    logic [7:0]  tblLimitIn;
    logic [7:0]  msgWordsIn;
    logic [8:0]  msgPlusOne;
    logic [16:0] bitsRounded;
    logic [11:0] nWordsNew;

    // Table entries and message words (length word included) never exceed the coder buffer.
    always_comb begin
        msgPlusOne  = {1'b0, msg_len} + 9'd1;
        tblLimitIn  = ({1'b0, tbl_count} > DEPTH9) ? DEPTH9[7:0] : tbl_count;
        msgWordsIn  = (msgPlusOne > DEPTH9) ? DEPTH9[7:0] : msgPlusOne[7:0];
        bitsRounded = {1'b0, coder_data_out[31:16]} + 17'd47;
        nWordsNew   = bitsRounded[16:5];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            idx                 <= '0;
            tblLimit            <= '0;
            msgWords            <= '0;
            msgLenReg           <= '0;
            wordCnt             <= '0;
            nWords              <= '0;
            postReset           <= 1'b1;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            tbl_addr            <= '0;
            msg_addr            <= '0;
            coder_ce            <= 1'b0;
            coder_data_loaded   <= 1'b0;
            coder_msg_loaded    <= 1'b0;
            coder_manual_reset  <= 1'b0;
            coder_symbol        <= '0;
            coder_symbol_length <= '0;
            coder_character     <= '0;
            coder_message       <= '0;
            out_valid           <= 1'b0;
            out_data            <= '0;
            out_last            <= 1'b0;
        end else begin
            done               <= 1'b0;
            err                <= 1'b0;
            coder_manual_reset <= postReset;
            postReset          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tblLimit  <= tblLimitIn;
                        msgWords  <= msgWordsIn;
                        msgLenReg <= msg_len;
                        idx       <= '0;
                        tbl_addr  <= '0;
                        msg_addr  <= 8'hFF;
                        wordCnt   <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                // cnt 0: address out, 1: read data valid -> register, 2: setup before ce rise
                FETCH: begin
                    if (cnt == 16'd0) begin
                        cnt <= 16'd1;
                    end else if (cnt == 16'd1) begin
                        coder_symbol        <= tbl_symbol;
                        coder_symbol_length <= tbl_length;
                        coder_character     <= tbl_char;
                        coder_message       <= (idx == 8'd0) ? msgLenReg : msg_char;
                        coder_data_loaded   <= (idx >= tblLimit);
                        coder_msg_loaded    <= (idx >= msgWords);
                        cnt                 <= 16'd2;
                    end else begin
                        cnt      <= '0;
                        coder_ce <= 1'b1;
                        state    <= LOAD_HI;
                    end
                end
                LOAD_HI, READ_HI, FLUSH_HI: begin
                    if (cnt == HI_LAST) begin
                        cnt      <= '0;
                        coder_ce <= 1'b0;
                        state    <= (state == LOAD_HI) ? LOAD_LO :
                                    (state == READ_HI) ? READ_LO : FLUSH_LO;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LOAD_LO: begin
                    if (cnt == LO_LAST) begin
                        cnt <= '0;
                        if (coder_data_loaded && coder_msg_loaded) begin
                            state <= WAIT_READY;
                        end else begin
                            idx      <= idx + 8'd1;
                            tbl_addr <= idx + 8'd1;
                            msg_addr <= idx;
                            state    <= FETCH;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_READY: begin
                    if (coder_data_ready != '0) begin
                        cnt      <= '0;
                        coder_ce <= 1'b1;
                        state    <= READ_HI;
                    end else if (cnt == TO_LAST) begin
                        coder_manual_reset <= 1'b1;
                        err                <= 1'b1;
                        done               <= 1'b1;
                        busy               <= 1'b0;
                        cnt                <= '0;
                        state              <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                READ_LO: begin
                    if (cnt == LO_LAST) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= coder_data_out;
                        // Word 0 carries the bit count, which fixes how many words follow.
                        if (wordCnt == 12'd0) begin
                            nWords   <= nWordsNew;
                            out_last <= (nWordsNew == 12'd1);
                        end else begin
                            out_last <= (wordCnt == nWords - 12'd1);
                        end
                        state <= EMIT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        wordCnt   <= wordCnt + 12'd1;
                        coder_ce  <= 1'b1;
                        cnt       <= '0;
                        state     <= out_last ? FLUSH_HI : READ_HI;
                    end
                end
                FLUSH_LO: begin
                    if (cnt == LO_LAST) begin
                        cnt   <= '0;
                        state <= CLEAR_WAIT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CLEAR_WAIT: begin
                    if (cnt == CLR_LAST) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_huff_coder_sequencer.sv
// Directed bench for huff_coder_sequencer with sync-read table/message memories
// and a small behavioural Huffman coder answering the strobe protocol.
module tb_huff_coder_sequencer;
    localparam int HI  = 4;
    localparam int LO  = 4;
    localparam int CLR = 210;
    localparam int TMO = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  tbl_count = '0;
    logic [7:0]  msg_len = '0;
    logic        busy, done, err;
    logic [7:0]  tbl_addr, msg_addr;
    logic [7:0]  tbl_symbol = '0, tbl_char = '0, msg_char = '0;
    logic [31:0] tbl_length = '0;
    logic        coder_ce, coder_data_loaded, coder_msg_loaded, coder_manual_reset;
    logic [7:0]  coder_symbol, coder_character, coder_message;
    logic [31:0] coder_symbol_length;
    logic [15:0] coder_data_ready = '0;
    logic [31:0] coder_data_out = '0;
    logic        out_valid, out_last;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;

    huff_coder_sequencer #(
        .DEPTH(100), .STROBE_HI(HI), .STROBE_LO(LO), .CLEAR_CYCLES(CLR), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .tbl_count(tbl_count), .msg_len(msg_len),
        .busy(busy), .done(done), .err(err),
        .tbl_addr(tbl_addr), .tbl_symbol(tbl_symbol), .tbl_length(tbl_length), .tbl_char(tbl_char),
        .msg_addr(msg_addr), .msg_char(msg_char),
        .coder_ce(coder_ce), .coder_data_loaded(coder_data_loaded), .coder_msg_loaded(coder_msg_loaded),
        .coder_manual_reset(coder_manual_reset), .coder_symbol(coder_symbol),
        .coder_symbol_length(coder_symbol_length), .coder_character(coder_character),
        .coder_message(coder_message), .coder_data_ready(coder_data_ready),
        .coder_data_out(coder_data_out), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    logic [7:0]  tblSymMem [0:255];
    logic [31:0] tblLenMem [0:255];
    logic [7:0]  tblCharMem [0:255];
    logic [7:0]  msgMem [0:255];

    always @(posedge clock) begin
        tbl_symbol <= tblSymMem[tbl_addr];
        tbl_length <= tblLenMem[tbl_addr];
        tbl_char   <= tblCharMem[tbl_addr];
        msg_char   <= msgMem[msg_addr];
    end

    // Coder model state
    logic [7:0]  tSym [0:127];
    logic [31:0] tLen [0:127];
    logic [7:0]  tChar [0:127];
    logic [7:0]  mWord [0:127];
    int          nT = 0, nM = 0, readIdx = 0;
    logic        phase = 1'b0;
    logic        stuckReady = 1'b0;

    // Monitor state
    int          cycleNo = 0, ceRises = 0, loadStrobes = 0, nBeats = 0;
    int          doneCount = 0, mrCount = 0, lastCeFall = 0, doneGap = 0;
    logic [1:0]  lastFlags = '0;
    logic        doneErr = 1'b0, doneMr = 1'b0;
    logic [31:0] beatData [0:7];
    logic        beatLast [0:7];
    int          beatCycle [0:7];
    logic        clearMon = 1'b0;
    logic        prevCe = 1'b0;

    int checks = 0;
    int passed = 0;

    function automatic int encBits();
        int total;
        total = 0;
        for (int m = 1; m < nM && m <= int'(mWord[0]); m++) begin
            for (int t = 0; t < nT; t++) begin
                if (tChar[t] == mWord[m]) begin
                    total += int'(tLen[t]);
                    break;
                end
            end
        end
        return total;
    endfunction

    function automatic logic [31:0] encWord(input int w);
        logic        s [0:1023];
        logic [15:0] hdr;
        logic [31:0] r;
        int          p;
        for (int i = 0; i < 1024; i++) s[i] = 1'b0;
        hdr = 16'(encBits());
        for (int i = 0; i < 16; i++) s[i] = hdr[15-i];
        p = 16;
        for (int m = 1; m < nM && m <= int'(mWord[0]); m++) begin
            for (int t = 0; t < nT; t++) begin
                if (tChar[t] == mWord[m]) begin
                    for (int b = int'(tLen[t]) - 1; b >= 0 && b < 8; b--) begin
                        if (p < 1024) s[p] = tSym[t][b];
                        p++;
                    end
                    break;
                end
            end
        end
        r = '0;
        if (w >= 0 && w < 32) begin
            for (int i = 0; i < 32; i++) r[31-i] = s[w*32+i];
        end
        return r;
    endfunction

    always @(negedge clock) begin
        cycleNo <= cycleNo + 1;
        prevCe  <= coder_ce;
        if (clearMon) begin
            ceRises <= 0; loadStrobes <= 0; nBeats <= 0; doneCount <= 0; mrCount <= 0;
            lastFlags <= '0; doneErr <= 1'b0; doneMr <= 1'b0; doneGap <= 0;
        end else begin
            if (coder_ce && !prevCe) begin
                ceRises <= ceRises + 1;
                if (!phase) begin
                    loadStrobes <= loadStrobes + 1;
                    lastFlags   <= {coder_data_loaded, coder_msg_loaded};
                end
            end
            if (!coder_ce && prevCe) lastCeFall <= cycleNo;
            if (out_valid && out_ready && nBeats < 8) begin
                beatData[nBeats]  <= out_data;
                beatLast[nBeats]  <= out_last;
                beatCycle[nBeats] <= cycleNo;
                nBeats            <= nBeats + 1;
            end
            if (coder_manual_reset) mrCount <= mrCount + 1;
            if (done) begin
                doneCount <= doneCount + 1;
                doneErr   <= err;
                doneMr    <= coder_manual_reset;
                doneGap   <= cycleNo - lastCeFall;
            end
        end
        if (clearMon || reset || coder_manual_reset) begin
            phase <= 1'b0; nT <= 0; nM <= 0; readIdx <= 0; coder_data_ready <= '0;
        end else if (coder_ce && !prevCe) begin
            if (!phase) begin
                if (!coder_data_loaded && nT < 128) begin
                    tSym[nT]  <= coder_symbol;
                    tLen[nT]  <= coder_symbol_length;
                    tChar[nT] <= coder_character;
                    nT        <= nT + 1;
                end
                if (!coder_msg_loaded && nM < 128) begin
                    mWord[nM] <= coder_message;
                    nM        <= nM + 1;
                end
                if (coder_data_loaded && coder_msg_loaded) begin
                    phase <= 1'b1;
                    if (!stuckReady) coder_data_ready <= 16'h0001;
                end
            end else begin
                coder_data_out <= encWord(readIdx);
                readIdx        <= readIdx + 1;
            end
        end
    end

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            tblSymMem[i] = '0; tblLenMem[i] = '0; tblCharMem[i] = '0; msgMem[i] = '0;
        end
    endtask

    task automatic load_space_table();
        clear_mems();
        tblSymMem[0] = 8'b10; tblLenMem[0] = 32'd2; tblCharMem[0] = 8'h20;
        msgMem[0] = 8'h20; msgMem[1] = 8'h20;
    endtask

    task automatic load_ab_table();
        logic [55:0] msg;
        clear_mems();
        tblSymMem[0] = 8'hA5; tblLenMem[0] = 32'd8; tblCharMem[0] = 8'h61;
        tblSymMem[1] = 8'h0C; tblLenMem[1] = 32'd4; tblCharMem[1] = 8'h62;
        msg = "aaabbbb";
        for (int i = 0; i < 7; i++) msgMem[i] = msg[8*(6-i) +: 8];
    endtask

    task automatic clear_mon();
        @(posedge clock); #1 clearMon = 1'b1;
        @(posedge clock); #1 clearMon = 1'b0;
    endtask

    task automatic start_job(input logic [7:0] tc, input logic [7:0] ml);
        @(posedge clock); #1;
        tbl_count = tc; msg_len = ml; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock); #1;
            if (doneCount > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({busy, done, err, out_valid, out_last, coder_ce, coder_data_loaded, coder_msg_loaded, coder_manual_reset} !== 9'b0)
            $display("FAIL reset_flags: got %b want 0", {busy, done, err, out_valid, out_last, coder_ce, coder_data_loaded, coder_msg_loaded, coder_manual_reset});
        else passed++;
        checks++;
        if ({tbl_addr, msg_addr, out_data, coder_message} !== 56'b0)
            $display("FAIL reset_data: got %h want 0", {tbl_addr, msg_addr, out_data, coder_message});
        else passed++;
        clear_mon();
        @(posedge clock); #1 reset = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        checks++;
        if (mrCount !== 1) $display("FAIL reset_mr_pulse: got %0d pulses want 1", mrCount);
        else passed++;
    endtask

    task automatic test_header_only();
        bit ok;
        clear_mems();
        clear_mon();
        start_job(8'd3, 8'd0);
        wait_done(2000, ok);
        checks++;
        if (!ok) $display("FAIL hdr_done_timeout: no done within 2000 cycles");
        else passed++;
        checks++;
        if (loadStrobes !== 4) $display("FAIL hdr_load_strobes: got %0d want 4", loadStrobes);
        else passed++;
        checks++;
        if (lastFlags !== 2'b11) $display("FAIL hdr_final_flags: got %b want 11", lastFlags);
        else passed++;
        checks++;
        if (nBeats !== 1 || beatData[0] !== 32'h0 || beatLast[0] !== 1'b1)
            $display("FAIL hdr_beat: got n=%0d data=%h last=%b want n=1 data=00000000 last=1", nBeats, beatData[0], beatLast[0]);
        else passed++;
        checks++;
        if (doneGap !== LO + CLR) $display("FAIL hdr_clear_wait: got %0d want %0d", doneGap, LO + CLR);
        else passed++;
        checks++;
        if (doneErr !== 1'b0 || busy !== 1'b0) $display("FAIL hdr_done_state: got err=%b busy=%b want 0 0", doneErr, busy);
        else passed++;
    endtask

    task automatic test_two_spaces();
        bit ok;
        load_space_table();
        clear_mon();
        start_job(8'd1, 8'd2);
        repeat (20) @(posedge clock);
        start_job(8'd5, 8'd9);
        wait_done(2000, ok);
        checks++;
        if (!ok) $display("FAIL sp_done_timeout: no done within 2000 cycles");
        else passed++;
        checks++;
        if (loadStrobes !== 4) $display("FAIL sp_load_strobes: got %0d want 4", loadStrobes);
        else passed++;
        checks++;
        if (nBeats !== 1 || beatData[0] !== 32'h0004_A000 || beatLast[0] !== 1'b1)
            $display("FAIL sp_beat: got n=%0d data=%h last=%b want n=1 data=0004a000 last=1", nBeats, beatData[0], beatLast[0]);
        else passed++;
        repeat (30) @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || doneCount !== 1) $display("FAIL sp_start_ignored: got busy=%b done=%0d want 0 1", busy, doneCount);
        else passed++;
    endtask

    task automatic test_two_words();
        bit ok;
        load_ab_table();
        clear_mon();
        start_job(8'd2, 8'd7);
        wait_done(3000, ok);
        checks++;
        if (!ok) $display("FAIL tw_done_timeout: no done within 3000 cycles");
        else passed++;
        checks++;
        if (loadStrobes !== 9) $display("FAIL tw_load_strobes: got %0d want 9", loadStrobes);
        else passed++;
        checks++;
        if (nBeats !== 2 || beatData[0] !== 32'h0028_A5A5 || beatLast[0] !== 1'b0)
            $display("FAIL tw_beat0: got n=%0d data=%h last=%b want n=2 data=0028a5a5 last=0", nBeats, beatData[0], beatLast[0]);
        else passed++;
        checks++;
        if (beatData[1] !== 32'hA5CC_CC00 || beatLast[1] !== 1'b1)
            $display("FAIL tw_beat1: got data=%h last=%b want a5cccc00 1", beatData[1], beatLast[1]);
        else passed++;
        checks++;
        if (beatCycle[1] - beatCycle[0] !== HI + LO + 1)
            $display("FAIL tw_throughput: got %0d cycles want %0d", beatCycle[1] - beatCycle[0], HI + LO + 1);
        else passed++;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        int bad;
        int ceSnap;
        load_ab_table();
        out_ready = 1'b0;
        clear_mon();
        start_job(8'd2, 8'd7);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) $display("FAIL bp_valid_timeout: out_valid never rose");
        else passed++;
        #1 ceSnap = ceRises;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b1 || out_data !== 32'h0028_A5A5 || out_last !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL bp_stall_stable: got %0d unstable cycles want 0", bad);
        else passed++;
        #1;
        checks++;
        if (ceRises !== ceSnap) $display("FAIL bp_no_strobe: got %0d ce rises during stall want 0", ceRises - ceSnap);
        else passed++;
        @(posedge clock); #1 out_ready = 1'b1;
        wait_done(2000, ok);
        checks++;
        if (!ok || nBeats !== 2 || beatData[1] !== 32'hA5CC_CC00 || beatLast[1] !== 1'b1)
            $display("FAIL bp_resume: got done=%b n=%0d data=%h last=%b want 1 2 a5cccc00 1", ok, nBeats, beatData[1], beatLast[1]);
        else passed++;
    endtask

    task automatic test_timeout();
        bit ok;
        clear_mems();
        stuckReady = 1'b1;
        clear_mon();
        start_job(8'd1, 8'd0);
        wait_done(1000, ok);
        stuckReady = 1'b0;
        checks++;
        if (!ok) $display("FAIL to_done_timeout: no done within 1000 cycles");
        else passed++;
        checks++;
        if (doneErr !== 1'b1 || doneMr !== 1'b1)
            $display("FAIL to_err_mr: got err=%b mr=%b at done want 1 1", doneErr, doneMr);
        else passed++;
        checks++;
        if (doneGap !== LO + TMO) $display("FAIL to_latency: got %0d want %0d", doneGap, LO + TMO);
        else passed++;
        checks++;
        if (busy !== 1'b0 || nBeats !== 0) $display("FAIL to_state: got busy=%b beats=%0d want 0 0", busy, nBeats);
        else passed++;
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        bit hit;
        load_space_table();
        clear_mon();
        start_job(8'd1, 8'd2);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock); #1;
            if (ceRises >= 2) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) $display("FAIL rm_reach_load: fewer than 2 strobes in 200 cycles");
        else passed++;
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({busy, done, err, out_valid, coder_ce, coder_data_loaded, coder_msg_loaded, coder_manual_reset, tbl_addr, msg_addr} !== 24'b0)
            $display("FAIL rm_outputs_cleared: got %h want 0",
                     {busy, done, err, out_valid, coder_ce, coder_data_loaded, coder_msg_loaded, coder_manual_reset, tbl_addr, msg_addr});
        else passed++;
        clear_mon();
        @(posedge clock); #1 reset = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        checks++;
        if (mrCount !== 1 || doneCount !== 0)
            $display("FAIL rm_mr_no_done: got mr=%0d done=%0d want 1 0", mrCount, doneCount);
        else passed++;
        clear_mon();
        start_job(8'd1, 8'd2);
        wait_done(2000, ok);
        checks++;
        if (!ok || nBeats !== 1 || beatData[0] !== 32'h0004_A000 || doneErr !== 1'b0)
            $display("FAIL rm_rerun: got done=%b n=%0d data=%h err=%b want 1 1 0004a000 0", ok, nBeats, beatData[0], doneErr);
        else passed++;
    endtask

    initial begin
        clear_mems();
        test_reset();
        test_header_only();
        test_two_spaces();
        test_two_words();
        test_backpressure();
        test_timeout();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
